// File: rtl/router_bench_axil_sequencer_pkg.sv
// Shared definitions for the router210 bench sequencer: register map, STATUS
// bit positions, CONTROL bits, error codes and FSM state encoding.
package router_bench_axil_sequencer_pkg;

    // Register offsets used by the sequencer (STATUS..INFO are contiguous words)
    localparam logic [5:0] REG_CONTROL = 6'h00;
    localparam logic [5:0] REG_STATUS  = 6'h04;
    localparam logic [5:0] REG_INFO    = 6'h28;

    // STATUS / CONTROL bit positions
    localparam int STATUS_BUSY_BIT   = 0;
    localparam int STATUS_DONE_BIT   = 1;
    localparam logic [31:0] CONTROL_START_WORD = 32'h0000_0001;

    // Result buffer geometry: word 0 is STATUS, word 9 is INFO
    localparam int         RES_WORDS    = 10;
    localparam logic [3:0] RES_LAST_IDX = 4'd9;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BRESP   = 2'd1,
        ERR_RRESP   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    typedef enum logic [3:0] {
        S_IDLE, S_WR, S_WRESP, S_GAP, S_ARS, S_RS, S_ARC, S_RC, S_FIN
    } state_e;

    // Byte address of result word k (k=0 is STATUS)
    function automatic logic [5:0] word_addr(input logic [3:0] k);
        return REG_STATUS + {k, 2'b00};
    endfunction

    // The engine has finished when done is set and busy is clear
    function automatic logic status_done(input logic [31:0] s);
        return s[STATUS_DONE_BIT] && !s[STATUS_BUSY_BIT];
    endfunction

endpackage

// File: rtl/router_bench_result_buf.sv
// 10x32 result register file: one synchronous write port, one combinational
// read port that returns zero for indices beyond the last word.
module router_bench_result_buf
    import router_bench_axil_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [3:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  raddr_i,
    output logic [31:0] rdata_o
);

    logic [31:0] mem_q [RES_WORDS];

    // Storage: cleared by reset, written one word per accepted read beat
    // NOTE: this memory is small and must read as zero after reset, so every
    // word is reset explicitly; large RAMs normally get no reset at all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RES_WORDS; i++) mem_q[i] <= '0;
        end else if (we_i && waddr_i <= RES_LAST_IDX) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: out-of-range index reads as zero
    always_comb begin
        rdata_o = '0;
        if (raddr_i <= RES_LAST_IDX) rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/router_bench_axil_sequencer.sv
// AXI4-Lite initiator that starts a router210 bench run, polls STATUS until
// done, then collects STATUS..INFO into a result buffer for readout.
module router_bench_axil_sequencer
    import router_bench_axil_sequencer_pkg::*;
#(
    parameter int POLL_GAP  = 16,
    parameter int MAX_POLLS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    output logic [5:0]  m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [5:0]  m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        busy,
    output logic        finished,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] poll_count,
    input  logic [3:0]  res_idx,
    output logic [31:0] res_data
);

    localparam logic [15:0] GAP_LAST    = 16'(POLL_GAP - 1);
    localparam logic [15:0] POLL_LIMIT  = 16'(MAX_POLLS);

    state_e      state_q;
    logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [5:0]  araddr_q;
    logic        busy_q, finished_q, error_q;
    err_code_e   err_code_q;
    logic [15:0] poll_count_q;
    logic [15:0] gap_cnt_q;
    logic [3:0]  word_q;

    logic        buf_we_d;
    logic [3:0]  buf_waddr_d;
    logic [31:0] buf_wdata_d;

    // The write channel carries a single fixed transfer: CONTROL.start
    assign m_axi_awaddr  = REG_CONTROL;
    assign m_axi_wdata   = CONTROL_START_WORD;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign busy          = busy_q;
    assign finished      = finished_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign poll_count    = poll_count_q;

    // Buffer write: the done STATUS beat lands in word 0, every collect beat
    // in its own word (even with a bad rresp, so the failing word is visible)
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        buf_we_d    = 1'b0;
        buf_waddr_d = word_q;
        buf_wdata_d = m_axi_rdata;
        if (rready_q && m_axi_rvalid) begin
            if (state_q == S_RC) begin
                buf_we_d = 1'b1;
            end else if (state_q == S_RS && m_axi_rresp == 2'b00 &&
                         status_done(m_axi_rdata)) begin
                buf_we_d    = 1'b1;
                buf_waddr_d = 4'd0;
            end
        end
    end

    // Sequencer FSM with all AXI channel controls and status held in registers
    // NOTE: state is updated with non-blocking assignments so every branch
    // sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            araddr_q     <= '0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
            poll_count_q <= '0;
            gap_cnt_q    <= '0;
            word_q       <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_FIN: begin
                    if (go) begin
                        finished_q   <= 1'b0;
                        error_q      <= 1'b0;
                        err_code_q   <= ERR_NONE;
                        poll_count_q <= '0;
                        busy_q       <= 1'b1;
                        awvalid_q    <= 1'b1;
                        wvalid_q     <= 1'b1;
                        state_q      <= S_WR;
                    end
                end
                S_WR: begin
                    // AW and W complete independently; either may go first
                    if (m_axi_awready) awvalid_q <= 1'b0;
                    if (m_axi_wready)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        if (m_axi_bresp != 2'b00) begin
                            error_q    <= 1'b1;
                            err_code_q <= ERR_BRESP;
                            finished_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_FIN;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        araddr_q  <= REG_STATUS;
                        arvalid_q <= 1'b1;
                        state_q   <= S_ARS;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 16'd1;
                    end
                end
                S_ARS, S_ARC: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        if (state_q == S_ARS) begin
                            poll_count_q <= poll_count_q + 16'd1;
                            state_q      <= S_RS;
                        end else begin
                            state_q <= S_RC;
                        end
                    end
                end
                S_RS: begin
                    if (m_axi_rvalid) begin
                        rready_q <= 1'b0;
                        if (m_axi_rresp != 2'b00) begin
                            error_q    <= 1'b1;
                            err_code_q <= ERR_RRESP;
                            finished_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_FIN;
                        end else if (status_done(m_axi_rdata)) begin
                            word_q    <= 4'd1;
                            araddr_q  <= word_addr(4'd1);
                            arvalid_q <= 1'b1;
                            state_q   <= S_ARC;
                        end else if (poll_count_q == POLL_LIMIT) begin
                            error_q    <= 1'b1;
                            err_code_q <= ERR_TIMEOUT;
                            finished_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_FIN;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= S_GAP;
                        end
                    end
                end
                S_RC: begin
                    if (m_axi_rvalid) begin
                        rready_q <= 1'b0;
                        if (m_axi_rresp != 2'b00) begin
                            error_q    <= 1'b1;
                            err_code_q <= ERR_RRESP;
                            finished_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_FIN;
                        end else if (araddr_q == REG_INFO) begin
                            finished_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_FIN;
                        end else begin
                            word_q    <= word_q + 4'd1;
                            araddr_q  <= word_addr(word_q + 4'd1);
                            arvalid_q <= 1'b1;
                            state_q   <= S_ARC;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    router_bench_result_buf u_result_buf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (buf_we_d),
        .waddr_i (buf_waddr_d),
        .wdata_i (buf_wdata_d),
        .raddr_i (res_idx),
        .rdata_o (res_data)
    );

endmodule

// File: tb/tb_router_bench_axil_sequencer.sv
// Bench for router_bench_axil_sequencer: AXI4-Lite responder with random
// stalls, a stub engine with programmable done delay, and a run-level model.
module tb_router_bench_axil_sequencer;

    localparam int POLL_GAP  = 40;
    localparam int MAX_POLLS = 8;

    logic        clk = 1'b0;
    logic        rst, go;
    logic [5:0]  m_axi_awaddr;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic [5:0]  m_axi_araddr;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid, m_axi_rready;
    logic        busy, finished, error;
    logic [1:0]  err_code;
    logic [15:0] poll_count;
    logic [3:0]  res_idx;
    logic [31:0] res_data;

    router_bench_axil_sequencer #(.POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)) dut (
        .clk(clk), .rst(rst), .go(go),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .busy(busy), .finished(finished), .error(error), .err_code(err_code),
        .poll_count(poll_count), .res_idx(res_idx), .res_data(res_data)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Scenario configuration
    int          stall_max = 0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [5:0]  cfg_err_addr = 6'h3F;   // address answered with SLVERR
    logic [5:0]  cfg_hold_addr = 6'h3F;  // address whose read data never comes
    int          done_delay = 300;       // <0: engine never finishes
    logic [31:0] regs [10];
    logic [29:0] status_hi = '0;

    // Stub engine and responder logs
    bit          eng_run = 0;
    int          eng_start = 0;
    logic [5:0]  rd_log [$];
    logic [31:0] stat_log [$];
    int          aw_count = 0, w_count = 0;
    logic [5:0]  wr_addr_last = '0;
    logic [31:0] wr_data_last = '0;
    logic [3:0]  wr_strb_last = '0;
    int          viol = 0;

    // Model results
    logic [31:0] mbuf [10];
    logic [5:0]  exp_reads [$];
    int          exp_err = 0, exp_polls = 0;

    function automatic logic [31:0] reg_value(input logic [5:0] a);
        bit done;
        done = eng_run && done_delay >= 0 && (cycle - eng_start) >= done_delay;
        if (a == 6'h04) return {status_hi, done, !done};
        if (a >= 6'h08 && a <= 6'h28 && a[1:0] == 2'b00) return regs[(int'(a) - 4) / 4];
        return 32'h0;
    endfunction

    // Responder: decisions made at negedge, handshakes complete at the next posedge
    initial begin : responder
        int aw_wait, w_wait, ar_wait, b_wait, r_wait;
        bit aw_got, w_got, b_pend, r_pend, b_fire, r_fire;
        bit p_awv, p_aw_hs, p_wv, p_w_hs, p_arv, p_ar_hs;
        logic [5:0] p_awaddr, p_araddr, r_addr;
        logic [31:0] p_wdata;
        aw_wait = -1; w_wait = -1; ar_wait = -1; b_wait = 0; r_wait = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_fire = 0; r_fire = 0;
        p_awv = 0; p_aw_hs = 0; p_wv = 0; p_w_hs = 0; p_arv = 0; p_ar_hs = 0;
        p_awaddr = '0; p_araddr = '0; p_wdata = '0; r_addr = '0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_wait = -1; w_wait = -1; ar_wait = -1;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_fire = 0; r_fire = 0;
                p_awv = 0; p_aw_hs = 0; p_wv = 0; p_w_hs = 0; p_arv = 0; p_ar_hs = 0;
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                m_axi_arready = 0; m_axi_rvalid = 0; eng_run = 0;
            end else begin
                // Valid must stay high with stable payload until its handshake
                if (p_awv && !p_aw_hs && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) viol++;
                if (p_wv && !p_w_hs && (!m_axi_wvalid || m_axi_wdata != p_wdata)) viol++;
                if (p_arv && !p_ar_hs && (!m_axi_arvalid || m_axi_araddr != p_araddr)) viol++;
                if (b_fire) begin m_axi_bvalid = 0; b_fire = 0; end
                if (r_fire) begin m_axi_rvalid = 0; r_fire = 0; end
                // No read may overlap the write phase or another read
                if (m_axi_arvalid && (m_axi_awvalid || m_axi_wvalid || aw_got || w_got ||
                                      b_pend || m_axi_bvalid)) viol++;
                if (m_axi_arvalid && (r_pend || m_axi_rvalid)) viol++;

                if (m_axi_awvalid) begin
                    if (aw_wait < 0) aw_wait = int'($urandom_range(0, stall_max));
                    if (aw_wait == 0) begin
                        m_axi_awready = 1; aw_wait = -1; aw_got = 1;
                        aw_count++; wr_addr_last = m_axi_awaddr;
                    end else begin m_axi_awready = 0; aw_wait--; end
                end else begin m_axi_awready = 0; aw_wait = -1; end
                p_awv = m_axi_awvalid; p_aw_hs = m_axi_awvalid && m_axi_awready; p_awaddr = m_axi_awaddr;

                if (m_axi_wvalid) begin
                    if (w_wait < 0) w_wait = int'($urandom_range(0, stall_max));
                    if (w_wait == 0) begin
                        m_axi_wready = 1; w_wait = -1; w_got = 1; w_count++;
                        wr_data_last = m_axi_wdata; wr_strb_last = m_axi_wstrb;
                        if (m_axi_wdata[0]) begin eng_run = 1; eng_start = cycle; end
                    end else begin m_axi_wready = 0; w_wait--; end
                end else begin m_axi_wready = 0; w_wait = -1; end
                p_wv = m_axi_wvalid; p_w_hs = m_axi_wvalid && m_axi_wready; p_wdata = m_axi_wdata;

                if (aw_got && w_got) begin
                    aw_got = 0; w_got = 0; b_pend = 1;
                    b_wait = 1 + int'($urandom_range(0, stall_max));
                end
                if (b_pend) begin
                    if (b_wait == 0) begin m_axi_bvalid = 1; m_axi_bresp = cfg_bresp; b_pend = 0; end
                    else b_wait--;
                end
                if (m_axi_bvalid && m_axi_bready) b_fire = 1;

                if (m_axi_arvalid) begin
                    if (ar_wait < 0) ar_wait = int'($urandom_range(0, stall_max));
                    if (ar_wait == 0) begin
                        m_axi_arready = 1; ar_wait = -1;
                        r_pend = 1; r_addr = m_axi_araddr;
                        r_wait = 1 + int'($urandom_range(0, stall_max));
                        rd_log.push_back(m_axi_araddr);
                    end else begin m_axi_arready = 0; ar_wait--; end
                end else begin m_axi_arready = 0; ar_wait = -1; end
                p_arv = m_axi_arvalid; p_ar_hs = m_axi_arvalid && m_axi_arready; p_araddr = m_axi_araddr;

                if (r_pend && r_addr != cfg_hold_addr) begin
                    if (r_wait == 0) begin
                        m_axi_rvalid = 1; m_axi_rdata = reg_value(r_addr);
                        m_axi_rresp = (r_addr == cfg_err_addr) ? 2'b10 : 2'b00;
                        r_pend = 0;
                        if (r_addr == 6'h04) stat_log.push_back(m_axi_rdata);
                    end else r_wait--;
                end
                if (m_axi_rvalid && m_axi_rready) r_fire = 1;
            end
        end
    end

    // Expected outcome of the run just finished, from the STATUS values served
    task automatic build_expect();
        bit done = 0;
        int p = 0;
        exp_reads.delete(); exp_err = 0; exp_polls = 0;
        if (cfg_bresp != 2'b00) begin exp_err = 1; return; end
        while (!done && exp_err == 0) begin
            logic [31:0] st;
            exp_reads.push_back(6'h04); exp_polls++;
            st = (p < stat_log.size()) ? stat_log[p] : 32'h1;
            p++;
            if (cfg_err_addr == 6'h04) exp_err = 2;
            else if (st[1] && !st[0]) begin done = 1; mbuf[0] = st; end
            else if (exp_polls == MAX_POLLS) exp_err = 3;
        end
        if (done) begin
            for (int k = 1; k <= 9; k++) begin
                logic [5:0] a;
                a = 6'(4 + 4 * k);
                exp_reads.push_back(a); mbuf[k] = regs[k];
                if (a == cfg_err_addr) begin exp_err = 2; break; end
            end
        end
    endtask

    function automatic bit reads_ok();
        if (rd_log.size() != exp_reads.size()) return 0;
        foreach (rd_log[i]) if (rd_log[i] !== exp_reads[i]) return 0;
        return 1;
    endfunction

    // Number of readout words (idx 0..15) differing from the model buffer
    task automatic buf_bad(output int bad);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            res_idx = 4'(i);
            #1;
            if (res_data !== ((i < 10) ? mbuf[i] : 32'h0)) bad++;
        end
        res_idx = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1; go = 0; res_idx = 0;
        for (int i = 0; i < 10; i++) mbuf[i] = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic start_run();
        @(negedge clk);
        rd_log.delete(); stat_log.delete();
        aw_count = 0; w_count = 0; viol = 0; eng_run = 0;
        wr_addr_last = '1; wr_data_last = '0; wr_strb_last = '0;
        status_hi = 30'($urandom);
        for (int i = 0; i < 10; i++) regs[i] = $urandom;
        go = 1;
        @(negedge clk);
        go = 0;
    endtask

    task automatic wait_finish(input string tag);
        bit ok = 0;
        for (int i = 0; i < 5000; i++) begin
            if (finished) begin ok = 1; break; end
            @(negedge clk);
        end
        n_total++;
        if (!ok) $display("FAIL %s finish: finished=%0b, required 1 within 5000 cycles", tag, finished);
        else n_pass++;
        build_expect();
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        n_total++; if (busy !== 1'b0 || finished !== 1'b0 || error !== 1'b0)
            $display("FAIL reset flags: busy/fin/err=%0b%0b%0b, required 000", busy, finished, error); else n_pass++;
        n_total++; if (err_code !== 2'd0 || poll_count !== 16'd0)
            $display("FAIL reset counters: err_code=%0d poll_count=%0d, required 0 0", err_code, poll_count); else n_pass++;
        n_total++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0)
            $display("FAIL reset channels: valid/ready=%b, required 00000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}); else n_pass++;
        buf_bad(bad);
        n_total++; if (bad !== 0) $display("FAIL reset buffer: %0d words nonzero, required 0", bad); else n_pass++;
    endtask

    task automatic test_normal_run();
        int bad;
        stall_max = 0; done_delay = 300; cfg_bresp = 0; cfg_err_addr = 6'h3F; cfg_hold_addr = 6'h3F;
        start_run();
        n_total++; if (busy !== 1'b1 || finished !== 1'b0)
            $display("FAIL normal busy: busy=%0b finished=%0b, required 1 0", busy, finished); else n_pass++;
        wait_finish("normal");
        n_total++; if ({aw_count, w_count, wr_addr_last, wr_data_last, wr_strb_last} !== {32'd1, 32'd1, 6'h00, 32'h1, 4'hF})
            $display("FAIL normal write: aw=%0d w=%0d addr=%h data=%h strb=%h, required 1 1 00 1 f",
                     aw_count, w_count, wr_addr_last, wr_data_last, wr_strb_last); else n_pass++;
        n_total++; if (error !== 1'b0 || err_code !== 2'd0 || busy !== 1'b0)
            $display("FAIL normal status: error=%0b err_code=%0d busy=%0b, required 0 0 0", error, err_code, busy); else n_pass++;
        n_total++; if (poll_count !== 16'(exp_polls) || exp_polls < 2)
            $display("FAIL normal polls: poll_count=%0d, required %0d (>=2)", poll_count, exp_polls); else n_pass++;
        n_total++; if (!reads_ok()) $display("FAIL normal reads: %0d reads, required %0d", rd_log.size(), exp_reads.size()); else n_pass++;
        buf_bad(bad);
        n_total++; if (bad !== 0) $display("FAIL normal buffer: %0d words wrong, required 0", bad); else n_pass++;
        n_total++; if (viol !== 0) $display("FAIL normal protocol: %0d violations, required 0", viol); else n_pass++;
    endtask

    task automatic test_bresp_error();
        int bad;
        cfg_bresp = 2'b10;
        start_run();
        wait_finish("bresp");
        n_total++; if (error !== 1'b1 || err_code !== 2'd1)
            $display("FAIL bresp code: error=%0b err_code=%0d, required 1 1", error, err_code); else n_pass++;
        n_total++; if (rd_log.size() !== 0 || poll_count !== 16'd0)
            $display("FAIL bresp reads: %0d reads poll_count=%0d, required 0 0", rd_log.size(), poll_count); else n_pass++;
        buf_bad(bad);
        n_total++; if (bad !== 0) $display("FAIL bresp buffer held: %0d words changed, required 0", bad); else n_pass++;
        cfg_bresp = 2'b00;
    endtask

    task automatic test_timeout();
        done_delay = -1;
        start_run();
        wait_finish("timeout");
        n_total++; if (error !== 1'b1 || err_code !== 2'd3)
            $display("FAIL timeout code: error=%0b err_code=%0d, required 1 3", error, err_code); else n_pass++;
        n_total++; if (poll_count !== 16'(MAX_POLLS))
            $display("FAIL timeout polls: poll_count=%0d, required %0d", poll_count, MAX_POLLS); else n_pass++;
        n_total++; if (!reads_ok() || rd_log.size() != MAX_POLLS)
            $display("FAIL timeout reads: %0d reads, required %0d of 0x04", rd_log.size(), MAX_POLLS); else n_pass++;
        done_delay = 300;
    endtask

    task automatic test_rresp_error();
        int bad;
        done_delay = 60; cfg_err_addr = 6'h18;
        start_run();
        wait_finish("rresp");
        n_total++; if (error !== 1'b1 || err_code !== 2'd2)
            $display("FAIL rresp code: error=%0b err_code=%0d, required 1 2", error, err_code); else n_pass++;
        n_total++; if (!reads_ok() || rd_log[$] !== 6'h18)
            $display("FAIL rresp reads: %0d reads last=%h, required %0d ending 18", rd_log.size(), rd_log[$], exp_reads.size()); else n_pass++;
        buf_bad(bad);
        n_total++; if (bad !== 0) $display("FAIL rresp buffer: %0d words wrong, required 0", bad); else n_pass++;
        cfg_err_addr = 6'h3F;
    endtask

    task automatic test_random_stalls();
        int bad;
        stall_max = 7;
        for (int r = 0; r < 4; r++) begin
            done_delay = int'($urandom_range(40, 250));
            start_run();
            wait_finish("stall");
            n_total++; if (err_code !== 2'd0 || poll_count !== 16'(exp_polls) || !reads_ok())
                $display("FAIL stall run %0d: err_code=%0d poll_count=%0d reads=%0d, required 0 %0d %0d",
                         r, err_code, poll_count, rd_log.size(), exp_polls, exp_reads.size()); else n_pass++;
            buf_bad(bad);
            n_total++; if (bad !== 0 || viol !== 0)
                $display("FAIL stall run %0d data: %0d words wrong %0d violations, required 0 0", r, bad, viol); else n_pass++;
        end
        stall_max = 0;
    endtask

    task automatic test_reset_mid_rc();
        bit reached = 0;
        int bad;
        done_delay = 60; cfg_hold_addr = 6'h14;
        start_run();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rd_log.size() > 0 && rd_log[$] == 6'h14 && m_axi_rready) begin reached = 1; break; end
        end
        n_total++; if (!reached) $display("FAIL midrst reach: word 4 read pending=%0b, required 1", reached); else n_pass++;
        #2 rst = 1;
        #1;
        n_total++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, busy, finished} !== 7'b0)
            $display("FAIL midrst outputs: %b, required 0000000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, busy, finished}); else n_pass++;
        for (int i = 0; i < 10; i++) mbuf[i] = '0;
        repeat (2) @(negedge clk);
        rst = 0; cfg_hold_addr = 6'h3F;
        buf_bad(bad);
        n_total++; if (bad !== 0) $display("FAIL midrst buffer: %0d words nonzero, required 0", bad); else n_pass++;
        start_run();
        wait_finish("rerun");
        buf_bad(bad);
        n_total++; if (err_code !== 2'd0 || !reads_ok() || bad !== 0)
            $display("FAIL rerun: err_code=%0d reads=%0d bad=%0d, required 0 %0d 0", err_code, rd_log.size(), exp_reads.size(), bad); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bad;
        done_delay = 50;
        start_run();
        repeat (20) @(negedge clk);
        go = 1;                         // ignored while busy
        @(negedge clk);
        go = 0;
        wait_finish("b2b first");
        start_run();                    // accepted straight from FIN
        n_total++; if (finished !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b restart: finished=%0b busy=%0b, required 0 1", finished, busy); else n_pass++;
        wait_finish("b2b second");
        buf_bad(bad);
        n_total++; if (aw_count !== 1 || err_code !== 2'd0 || !reads_ok() || bad !== 0)
            $display("FAIL b2b result: writes=%0d err_code=%0d bad=%0d, required 1 0 0", aw_count, err_code, bad); else n_pass++;
    endtask

    initial begin
        rst = 1; go = 0; res_idx = 0;
        test_reset();
        test_normal_run();
        test_bresp_error();
        test_timeout();
        test_rresp_error();
        test_random_stalls();
        test_reset_mid_rc();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
